ps2_key_event_decoder: RTL and testbench

//  Parametrised successor to the raw PS/2 byte monitor: consumes the PS2_Controller byte stream
//  (received_data / received_data_en), parses scan-code set 2 prefixes (E0, F0, E1) into key

---
 rtl/ps2_key_event_decoder_pkg.sv | 77 +++++++
 rtl/ps2_key_event_decoder_if.sv | 38 +++
 rtl/ps2_key_event_decoder_fifo.sv | 55 +++++
 rtl/ps2_key_event_decoder.sv | 213 +++++++++++++++++++++
 tb/tb_ps2_key_event_decoder.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_event_decoder_pkg.sv
// Shared scan-code set 2 constants, parser state encoding and key event type
// for the PS/2 key event decoder.
package ps2_pkg;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FA = 8'hFA;
  localparam logic [7:0] SC_FE = 8'hFE;
  localparam logic [7:0] SC_EE = 8'hEE;
  localparam logic [7:0] SC_00 = 8'h00;
  localparam logic [7:0] SC_FF = 8'hFF;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_Z     = 8'h1A;
  localparam logic [7:0] SC_X     = 8'h22;

  localparam logic [2:0] KEY_UP    = 3'd0;
  localparam logic [2:0] KEY_DOWN  = 3'd1;
  localparam logic [2:0] KEY_LEFT  = 3'd2;
  localparam logic [2:0] KEY_RIGHT = 3'd3;
  localparam logic [2:0] KEY_Z     = 3'd4;
  localparam logic [2:0] KEY_X     = 3'd5;
  localparam logic [2:0] KEY_NONE  = 3'd7;

  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } parser_state_t;

  typedef struct packed {
    logic       extended;
    logic       released;
    logic [7:0] code;
  } key_event_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_E0) || (b == SC_F0) || (b == SC_E1);
  endfunction

  // Keyboard status/ack bytes that carry no key information.
  function automatic logic is_status(input logic [7:0] b);
    return (b == SC_AA) || (b == SC_FA) || (b == SC_FE) ||
           (b == SC_EE) || (b == SC_00) || (b == SC_FF);
  endfunction

  function automatic logic [2:0] key_slot(input logic ext, input logic [7:0] code);
    logic [2:0] slot;
    slot = KEY_NONE;
    if (ext) begin
      case (code)
        SC_UP:    slot = KEY_UP;
        SC_DOWN:  slot = KEY_DOWN;
        SC_LEFT:  slot = KEY_LEFT;
        SC_RIGHT: slot = KEY_RIGHT;
        default:  slot = KEY_NONE;
      endcase
    end else begin
      case (code)
        SC_Z:    slot = KEY_Z;
        SC_X:    slot = KEY_X;
        default: slot = KEY_NONE;
      endcase
    end
    return slot;
  endfunction

endpackage

// File: rtl/ps2_key_event_decoder_if.sv
// Byte-in / event-out bundle between PS2_Controller, the decoder and game logic.
// master = decoder side, slave = byte source plus event consumer.
interface ps2_key_event_decoder_if #(
  parameter int DEPTH = 8
);

  logic [7:0]             received_data;
  logic                   received_data_en;
  logic                   evt_valid;
  logic [9:0]             evt_data;
  logic                   evt_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;
  logic [5:0]             keys_held;

  modport master (
    input  received_data,
    input  received_data_en,
    input  evt_ready,
    output evt_valid,
    output evt_data,
    output fifo_count,
    output overflow,
    output keys_held
  );

  modport slave (
    output received_data,
    output received_data_en,
    output evt_ready,
    input  evt_valid,
    input  evt_data,
    input  fifo_count,
    input  overflow,
    input  keys_held
  );

endinterface

// File: rtl/ps2_key_event_decoder_fifo.sv
// Show-ahead synchronous event FIFO; a push against a full FIFO with no
// concurrent pop is dropped and reported on the one-cycle drop output.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  key_event_t             push_data,
  input  logic                   pop,
  output key_event_t             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  key_event_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // A pop frees the slot the simultaneous push lands in, so full+pop still accepts.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code set 2 parser producing make/break events into a FIFO and
// tracking held game keys. Optional macro PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat makes.
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic                     CLOCK_50,
  input logic                     reset,
  ps2_key_event_decoder_if.master bus
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  parser_state_t    state;
  parser_state_t    state_nx;
  logic [2:0]       skip_cnt;
  logic [2:0]       skip_nx;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  logic       emit;
  key_event_t emit_ev;
  logic       is_repeat;
  logic       push;
  logic [2:0] slot;

  key_event_t fifo_head;
  logic       fifo_empty;
  logic       fifo_drop;
  logic       pop;
  logic       overflow;
  logic [5:0] keys_held;

  logic [7:0] rx_byte;
  logic       rx_en;

  assign rx_byte = bus.received_data;
  assign rx_en   = bus.received_data_en;
  assign tmo_hit = (state != ST_IDLE) && (tmo_cnt == TMO_LAST);

  // Parser state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_nx;
      skip_cnt <= skip_nx;
    end
  end

  // Idle counter only runs while a sequence is partially received
  always_ff @(posedge CLOCK_50) begin
    if (reset || rx_en || state == ST_IDLE || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Parser next state
  always_comb begin
    state_nx = state;
    skip_nx  = skip_cnt;
    if (rx_en) begin
      case (state)
        ST_IDLE: begin
          if (rx_byte == SC_E0) begin
            state_nx = ST_EXT;
          end else if (rx_byte == SC_F0) begin
            state_nx = ST_BRK;
          end else if (rx_byte == SC_E1) begin
            state_nx = ST_SKIP;
            skip_nx  = PAUSE_TAIL;
          end
        end
        ST_EXT: begin
          state_nx = (rx_byte == SC_F0) ? ST_EXT_BRK : ST_IDLE;
        end
        ST_BRK, ST_EXT_BRK: begin
          state_nx = ST_IDLE;
        end
        ST_SKIP: begin
          skip_nx = skip_cnt - 1'b1;
          if (skip_cnt <= 3'd1) begin
            state_nx = ST_IDLE;
            skip_nx  = '0;
          end
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end else if (tmo_hit) begin
      state_nx = ST_IDLE;
    end
  end

  // Parser outputs: event emission on the final byte of a sequence
  always_comb begin
    emit    = 1'b0;
    emit_ev = '0;
    if (rx_en) begin
      case (state)
        ST_IDLE: begin
          if (!is_prefix(rx_byte) && !is_status(rx_byte)) begin
            emit    = 1'b1;
            emit_ev = '{extended: 1'b0, released: 1'b0, code: rx_byte};
          end
        end
        ST_EXT: begin
          if (!is_prefix(rx_byte)) begin
            emit    = 1'b1;
            emit_ev = '{extended: 1'b1, released: 1'b0, code: rx_byte};
          end
        end
        ST_BRK: begin
          if (!is_prefix(rx_byte)) begin
            emit    = 1'b1;
            emit_ev = '{extended: 1'b0, released: 1'b1, code: rx_byte};
          end
        end
        ST_EXT_BRK: begin
          if (!is_prefix(rx_byte)) begin
            emit    = 1'b1;
            emit_ev = '{extended: 1'b1, released: 1'b1, code: rx_byte};
          end
        end
        default: begin
          emit    = 1'b0;
          emit_ev = '0;
        end
      endcase
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       rep_vld;
  logic       rep_ext;
  logic [7:0] rep_code;
  logic       rep_match;

  assign rep_match = rep_vld && (rep_ext == emit_ev.extended) && (rep_code == emit_ev.code);
  assign is_repeat = emit && !emit_ev.released && rep_match;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rep_vld <= 1'b0;
    end else if (emit) begin
      if (!emit_ev.released) begin
        rep_vld <= 1'b1;
      end else if (rep_match) begin
        rep_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (emit && !emit_ev.released) begin
      rep_ext  <= emit_ev.extended;
      rep_code <= emit_ev.code;
    end
  end
`else
  assign is_repeat = 1'b0;
`endif

  assign push = emit && !is_repeat;

  // Held-key tracking sees every emitted event, filtered or dropped
  assign slot = key_slot(emit_ev.extended, emit_ev.code);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      keys_held <= '0;
    end else if (emit && slot != KEY_NONE) begin
      keys_held[slot] <= !emit_ev.released;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
    end
  end

  assign pop = bus.evt_ready && !fifo_empty;

  ps2_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLOCK_50),
    .rst       (reset),
    .push      (push),
    .push_data (emit_ev),
    .pop       (pop),
    .head      (fifo_head),
    .count     (bus.fifo_count),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign bus.evt_valid = !fifo_empty;
  assign bus.evt_data  = fifo_empty ? 10'd0 : fifo_head;
  assign bus.overflow  = overflow;
  assign bus.keys_held = keys_held;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench for ps2_key_event_decoder: parsing, FIFO limits, timeout,
// pause skipping, held keys and (build-dependent) typematic filtering.
module tb_ps2_key_event_decoder;

  localparam int DEPTH = 8;
  localparam int TMO   = 20;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  ps2_key_event_decoder_if #(.DEPTH(DEPTH)) bus ();

  ps2_key_event_decoder #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.received_data    = b;
    bus.received_data_en = 1'b1;
    @(negedge clk);
    bus.received_data_en = 1'b0;
  endtask

  task automatic pop_one();
    bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.evt_valid !== 1'b0 || bus.evt_data !== 10'h000 || bus.fifo_count !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_fifo valid=%b data=%h count=%0d, expected 0/000/0",
               bus.evt_valid, bus.evt_data, bus.fifo_count);
    end
    vectors++;
    if (bus.overflow !== 1'b0 || bus.keys_held !== 6'b000000) begin
      miscompares++;
      $display("FAIL reset_flags overflow=%b keys=%b, expected 0/000000", bus.overflow, bus.keys_held);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_make_break();
    send_byte(8'h1A);
    vectors++;
    if (bus.evt_valid !== 1'b1 || bus.evt_data !== 10'h01A || bus.keys_held !== 6'b010000) begin
      miscompares++;
      $display("FAIL z_make valid=%b data=%h keys=%b, expected 1/01A/010000",
               bus.evt_valid, bus.evt_data, bus.keys_held);
    end
    pop_one();
    send_byte(8'hF0);
    vectors++;
    if (bus.evt_valid !== 1'b0 || bus.keys_held !== 6'b010000) begin
      miscompares++;
      $display("FAIL z_brk_prefix valid=%b keys=%b, expected 0/010000", bus.evt_valid, bus.keys_held);
    end
    send_byte(8'h1A);
    vectors++;
    if (bus.evt_valid !== 1'b1 || bus.evt_data !== 10'h11A || bus.keys_held !== 6'b000000) begin
      miscompares++;
      $display("FAIL z_break valid=%b data=%h keys=%b, expected 1/11A/000000",
               bus.evt_valid, bus.evt_data, bus.keys_held);
    end
    pop_one();
    vectors++;
    if (bus.fifo_count !== 4'd0) begin
      miscompares++;
      $display("FAIL z_drained count=%0d, expected 0", bus.fifo_count);
    end
  endtask

  task automatic test_extended();
    send_byte(8'hE0);
    vectors++;
    if (bus.evt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL up_prefix valid=%b, expected 0", bus.evt_valid);
    end
    send_byte(8'h75);
    vectors++;
    if (bus.evt_valid !== 1'b1 || bus.evt_data !== 10'h275 || bus.keys_held !== 6'b000001) begin
      miscompares++;
      $display("FAIL up_make valid=%b data=%h keys=%b, expected 1/275/000001",
               bus.evt_valid, bus.evt_data, bus.keys_held);
    end
    pop_one();
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    vectors++;
    if (bus.evt_valid !== 1'b1 || bus.evt_data !== 10'h375 || bus.keys_held !== 6'b000000) begin
      miscompares++;
      $display("FAIL up_break valid=%b data=%h keys=%b, expected 1/375/000000",
               bus.evt_valid, bus.evt_data, bus.keys_held);
    end
    pop_one();
  endtask

  task automatic test_overflow();
    logic [9:0] exp_q[$];
    for (int i = 0; i <= DEPTH; i++) send_byte(8'h10 + 8'(i));
    vectors++;
    if (bus.fifo_count !== 4'(DEPTH) || bus.overflow !== 1'b1 || bus.evt_data !== 10'h010) begin
      miscompares++;
      $display("FAIL ovf_full count=%0d overflow=%b head=%h, expected %0d/1/010",
               bus.fifo_count, bus.overflow, bus.evt_data, DEPTH);
    end
    // pop and push on the same edge while full
    @(negedge clk);
    bus.received_data    = 8'h30;
    bus.received_data_en = 1'b1;
    bus.evt_ready        = 1'b1;
    @(negedge clk);
    bus.received_data_en = 1'b0;
    bus.evt_ready        = 1'b0;
    vectors++;
    if (bus.fifo_count !== 4'(DEPTH) || bus.overflow !== 1'b1 || bus.evt_data !== 10'h011) begin
      miscompares++;
      $display("FAIL ovf_pushpop count=%0d overflow=%b head=%h, expected %0d/1/011",
               bus.fifo_count, bus.overflow, bus.evt_data, DEPTH);
    end
    for (int i = 1; i < DEPTH; i++) exp_q.push_back(10'h010 + 10'(i));
    exp_q.push_back(10'h030);
    foreach (exp_q[i]) begin
      vectors++;
      if (bus.evt_valid !== 1'b1 || bus.evt_data !== exp_q[i]) begin
        miscompares++;
        $display("FAIL ovf_drain[%0d] valid=%b data=%h, expected 1/%h", i, bus.evt_valid, bus.evt_data, exp_q[i]);
      end
      pop_one();
    end
    pop_one();
    vectors++;
    if (bus.fifo_count !== 4'd0 || bus.evt_valid !== 1'b0 || bus.evt_data !== 10'h000) begin
      miscompares++;
      $display("FAIL pop_empty count=%0d valid=%b data=%h, expected 0/0/000",
               bus.fifo_count, bus.evt_valid, bus.evt_data);
    end
    // push with pop requested while empty: no bypass
    @(negedge clk);
    bus.received_data    = 8'h31;
    bus.received_data_en = 1'b1;
    bus.evt_ready        = 1'b1;
    @(negedge clk);
    bus.received_data_en = 1'b0;
    bus.evt_ready        = 1'b0;
    vectors++;
    if (bus.fifo_count !== 4'd1 || bus.evt_data !== 10'h031) begin
      miscompares++;
      $display("FAIL pushpop_empty count=%0d data=%h, expected 1/031", bus.fifo_count, bus.evt_data);
    end
    pop_one();
  endtask

  task automatic test_pause_and_status();
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    do_reset();
    foreach (pause_seq[i]) send_byte(pause_seq[i]);
    vectors++;
    if (bus.fifo_count !== 4'd0 || bus.evt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_silent count=%0d valid=%b, expected 0/0", bus.fifo_count, bus.evt_valid);
    end
    send_byte(8'h22);
    vectors++;
    if (bus.fifo_count !== 4'd1 || bus.evt_data !== 10'h022 || bus.keys_held !== 6'b100000) begin
      miscompares++;
      $display("FAIL after_pause count=%0d data=%h keys=%b, expected 1/022/100000",
               bus.fifo_count, bus.evt_data, bus.keys_held);
    end
    pop_one();
    send_byte(8'hAA);
    send_byte(8'hFA);
    vectors++;
    if (bus.fifo_count !== 4'd0 || bus.keys_held !== 6'b100000) begin
      miscompares++;
      $display("FAIL status_drop count=%0d keys=%b, expected 0/100000", bus.fifo_count, bus.keys_held);
    end
    send_byte(8'hF0);
    send_byte(8'h22);
    vectors++;
    if (bus.evt_data !== 10'h122 || bus.keys_held !== 6'b000000) begin
      miscompares++;
      $display("FAIL x_break data=%h keys=%b, expected 122/000000", bus.evt_data, bus.keys_held);
    end
    pop_one();
  endtask

  task automatic test_timeout();
    send_byte(8'hE0);
    repeat (TMO) @(negedge clk);
    send_byte(8'h6B);
    vectors++;
    if (bus.evt_data !== 10'h06B || bus.keys_held !== 6'b000000) begin
      miscompares++;
      $display("FAIL timeout_drop data=%h keys=%b, expected 06B/000000", bus.evt_data, bus.keys_held);
    end
    pop_one();
    send_byte(8'hE0);
    repeat (TMO - 3) @(negedge clk);
    send_byte(8'h74);
    vectors++;
    if (bus.evt_data !== 10'h274 || bus.keys_held !== 6'b001000) begin
      miscompares++;
      $display("FAIL timeout_short data=%h keys=%b, expected 274/001000", bus.evt_data, bus.keys_held);
    end
    pop_one();
    send_byte(8'hF0);
    do_reset();
    vectors++;
    if (bus.keys_held !== 6'b000000 || bus.fifo_count !== 4'd0) begin
      miscompares++;
      $display("FAIL midseq_reset keys=%b count=%0d, expected 000000/0", bus.keys_held, bus.fifo_count);
    end
    send_byte(8'h1A);
    vectors++;
    if (bus.evt_data !== 10'h01A || bus.keys_held !== 6'b010000) begin
      miscompares++;
      $display("FAIL after_reset data=%h keys=%b, expected 01A/010000", bus.evt_data, bus.keys_held);
    end
    pop_one();
  endtask

  task automatic test_typematic();
    logic [7:0] seq [6];
    logic [9:0] exp_q[$];
    seq = '{8'h1A, 8'h1A, 8'h1A, 8'hF0, 8'h1A, 8'h1A};
`ifdef PS2_TYPEMATIC_FILTER_EN
    exp_q = '{10'h01A, 10'h11A, 10'h01A};
`else
    exp_q = '{10'h01A, 10'h01A, 10'h01A, 10'h11A, 10'h01A};
`endif
    do_reset();
    foreach (seq[i]) send_byte(seq[i]);
    vectors++;
    if (bus.fifo_count !== 4'(exp_q.size()) || bus.keys_held !== 6'b010000) begin
      miscompares++;
      $display("FAIL typematic_count count=%0d keys=%b, expected %0d/010000",
               bus.fifo_count, bus.keys_held, exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (bus.evt_valid !== 1'b1 || bus.evt_data !== exp_q[i]) begin
        miscompares++;
        $display("FAIL typematic[%0d] valid=%b data=%h, expected 1/%h", i, bus.evt_valid, bus.evt_data, exp_q[i]);
      end
      pop_one();
    end
    vectors++;
    if (bus.evt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL typematic_empty valid=%b, expected 0", bus.evt_valid);
    end
  endtask

  initial begin
    vectors              = 0;
    miscompares          = 0;
    reset                = 1'b0;
    bus.received_data    = 8'h00;
    bus.received_data_en = 1'b0;
    bus.evt_ready        = 1'b0;
    test_reset();
    test_make_break();
    test_extended();
    test_overflow();
    test_pause_and_status();
    test_timeout();
    test_typematic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
